tone_i2s_synth: RTL
===================

Name: tone_i2s_synth

Overview:
- Downstream consumer of the beat-to-tone lookup. Takes a 32-bit tone frequency in Hz and synthesises a square wave at that pitch.
- Scales the wave by a 3-bit volume and serialises it as 16-bit stereo audio on a Pmod I2S-style four-wire DAC interface (mclk/lrck/sck/sdin).
- Tone value 20000 (and 0) is the silence code: output is digital zero.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz; the phase accumulator wraps at CLK_FREQ/2.
- SILENCE_MIN, 20000, any tone >= this value (or tone == 0) is treated as silence.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- tone  in  32  requested frequency in Hz, sampled every clk
- volume  in  3  0 = mute, 1..5 = amplitude levels, 6..7 saturate to 5
- enable  in  1  0 freezes the accumulator and forces sample to 0; I2S clocks keep running
- square  out  1  raw square wave at tone Hz (debug/LED)
- sample  out  16  signed sample currently being transmitted
- audio_mclk  out  1  master clock = clk/4
- audio_lrck  out  1  word select = clk/512; 0 = left, 1 = right
- audio_sck  out  1  bit clock = clk/16
- audio_sdin  out  1  serial data, MSB first

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0, accumulator 0, frame counter 0, shift data 0, square 0.
- Frame counter: 9-bit free-running counter incremented every clk.
  - audio_mclk = cnt[1], audio_sck = cnt[3], audio_lrck = cnt[8].
  - All four I2S signals are registered outputs derived from the same counter, so they are phase-aligned.
- Phase accumulator (32-bit unsigned, sequential):
  - Each clk with enable=1 and non-silent tone: if acc + tone >= CLK_FREQ/2, then acc <= acc + tone - CLK_FREQ/2 and square toggles; else acc <= acc + tone.
  - The sum is computed at 33 bits; no overflow for tone < SILENCE_MIN.
- Silence (tone == 0 or tone >= SILENCE_MIN) or enable=0: acc <= 0, square <= 0, target amplitude = 0.
- A tone change takes effect on the next clk. The accumulator is not cleared on a change between two non-silent tones (phase-continuous).
- Amplitude table: volume 1..5 -> 0x0400, 0x0800, 0x1000, 0x2000, 0x4000; volume 0 -> 0.
- Sample value: square=1 -> +amp; square=0 -> -amp in two's complement (e.g. 0xFC00 at volume 1); silence -> 0x0000.
- Sample capture: sample is registered only on the clk where cnt == 511, so it is stable for a full frame. Both channels carry the same sample.
- Serialisation:
  - During the frame, audio_sdin = sample[15 - cnt[7:4]]. This places bit 15 in the first sck period after each lrck edge: left-justified, no 1-bit delay.
  - Data changes on sck falling edges and is stable on rising edges.
  - 16 bits per channel, 32 sck per frame.
- Latency: a tone, volume or enable change appears on audio_sdin at the start of the frame following the next cnt == 511 edge, at most 513 clk later.
- Reset mid-frame: the counter restarts at 0 and lrck drops immediately. The first frame after reset transmits 0x0000.

Optional Feature:
- VOL_RAMP_EN defined: the applied amplitude is a register that moves toward the table target by 0x0100 per frame (at cnt == 511), up or down, clamped at the target. This prevents clicks on volume changes and silence entry/exit. Example: 0 -> 0x4000 takes 64 frames. Reset value 0.
- Not defined: the applied amplitude equals the table target immediately.

Test Plan:
- Release reset, tone=20000, volume=3, enable=1 -> audio_mclk period 4 clk, audio_sck period 16, audio_lrck period 512; square stays 0; audio_sdin stays 0 for 4 frames.
- tone=262, volume=1 -> square toggles every 190839 or 190840 clk; rising-edge spacing averages 381679.4 clk over 10 periods; each frame transmits 0x0400 or 0xFC00 on both lrck halves, MSB first.
- tone=440, volume sequence 0, 5, 7 -> transmitted magnitudes 0x0000, 0x4000, 0x4000 (saturation).
- tone=440 running, enable dropped to 0 -> square forced to 0 on the next clk; next captured sample is 0x0000; I2S clocks continue uninterrupted.
- Assert rst_n low at cnt=300 for 3 clk -> all outputs 0 asynchronously; after release, lrck rises exactly 256 clk later; first frame transmits 0x0000.
- With VOL_RAMP_EN, tone=392, volume 0 -> 5 -> transmitted magnitude increases by 0x0100 per frame and reaches 0x4000 after 64 frames. Without the macro, it reaches 0x4000 in the first frame after the change.

Source files
------------

// File: rtl/tone_i2s_synth.sv
// tone_i2s_synth: square-wave tone synthesiser with a Pmod I2S-style DAC output.
// A phase accumulator toggles a square wave at the requested pitch.
// A 3-bit volume scales the wave to a signed 16-bit sample.
// The sample is captured once per 512-clk frame.
// It is sent left-justified and MSB first on both channels.
// Optional macro VOL_RAMP_EN: when defined, the applied amplitude ramps toward
// its target by 0x0100 per frame instead of jumping to it immediately.
module tone_i2s_synth #(
    parameter int unsigned CLK_FREQ    = 100_000_000,
    parameter int unsigned SILENCE_MIN = 20000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] tone,
    input  logic [2:0]  volume,
    input  logic        enable,
    output logic        square,
    output logic [15:0] sample,
    output logic        audio_mclk,
    output logic        audio_lrck,
    output logic        audio_sck,
    output logic        audio_sdin
);

    localparam logic [32:0] HALF_FREQ = 33'(CLK_FREQ / 2);
    localparam logic [15:0] AMP_STEP  = 16'h0100;

    logic [8:0]  cnt_q, cnt_d;
    logic [31:0] acc_q, acc_d;
    logic        square_q, square_d;
    logic [15:0] sample_q, sample_d;
    logic        sdin_q, sdin_d;
    logic        silent;
    logic [15:0] amp_target;
    logic [15:0] amp_applied;
    logic [32:0] acc_sum;
    logic        frame_end;

    assign frame_end = (cnt_q == 9'd511);

    // Decode silence and map the volume code to its target amplitude
    always_comb begin
        silent     = (tone == 32'd0) || (tone >= SILENCE_MIN) || !enable;
        amp_target = 16'h0000;
        case (volume)
            3'd0:    amp_target = 16'h0000;
            3'd1:    amp_target = 16'h0400;
            3'd2:    amp_target = 16'h0800;
            3'd3:    amp_target = 16'h1000;
            3'd4:    amp_target = 16'h2000;
            default: amp_target = 16'h4000;
        endcase
        if (silent) begin
            amp_target = 16'h0000;
        end
    end

`ifdef VOL_RAMP_EN
    logic [15:0] amp_q, amp_d;

    // Step the applied amplitude toward the target once per frame, never overshooting
    always_comb begin
        amp_d = amp_q;
        if (frame_end) begin
            if (amp_q < amp_target) begin
                amp_d = ((amp_target - amp_q) > AMP_STEP) ? (amp_q + AMP_STEP) : amp_target;
            end else if (amp_q > amp_target) begin
                amp_d = ((amp_q - amp_target) > AMP_STEP) ? (amp_q - AMP_STEP) : amp_target;
            end
        end
    end

    // Hold the ramped amplitude between frames
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            amp_q <= 16'h0000;
        end else begin
            amp_q <= amp_d;
        end
    end

    assign amp_applied = amp_d;
`else
    assign amp_applied = amp_target;
`endif

    // Next-state logic: frame counter, phase accumulator, sample capture and serial bit
    always_comb begin
        cnt_d    = cnt_q + 9'd1;
        acc_d    = acc_q;
        square_d = square_q;
        sample_d = sample_q;
        acc_sum  = {1'b0, acc_q} + {1'b0, tone};

        if (silent) begin
            acc_d    = 32'd0;
            square_d = 1'b0;
        end else if (acc_sum >= HALF_FREQ) begin
            acc_d    = 32'(acc_sum - HALF_FREQ);
            square_d = ~square_q;
        end else begin
            acc_d    = acc_sum[31:0];
        end

        if (frame_end) begin
            sample_d = square_q ? amp_applied : (16'h0000 - amp_applied);
        end

        sdin_d = sample_d[4'd15 - cnt_d[7:4]];
    end

    // State registers; all cleared asynchronously so the interface goes quiet at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= 9'd0;
            acc_q    <= 32'd0;
            square_q <= 1'b0;
            sample_q <= 16'h0000;
            sdin_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            square_q <= square_d;
            sample_q <= sample_d;
            sdin_q   <= sdin_d;
        end
    end

    assign square     = square_q;
    assign sample     = sample_q;
    assign audio_mclk = cnt_q[1];
    assign audio_sck  = cnt_q[3];
    assign audio_lrck = cnt_q[8];
    assign audio_sdin = sdin_q;

endmodule
